keypad_responder: RTL and testbench
===================================

# keypad_responder

Behavioural-synthesizable 4x4 matrix-keypad responder: the "key side" of the keypad scan interface, the other end of the column-driving keypad scanner. It accepts a key-press request, then drives the `row` lines in response to the scanner's `col` drive. The press follows a programmable mechanical profile: contact bounce, a hold lasting N full scans, and release bounce. It is used for on-board loopback self-test of the keypad scanner and the debounce path, and as a bench model.

## Interface
- `HOLD_SCANS`, 8: number of complete column scans the key is held closed (≥1).
- `BOUNCE_TOGGLES`, 3: number of open/close bounce pairs at press and at release (0 = clean edges).
- `BOUNCE_CLKS`, 1000: clocks per bounce phase (≥1).
- `clk`  in  1  system clock, single domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  press request; level, sampled only in IDLE.
- `key_code`  in  4  key to press; [3:2] = row index, [1:0] = column index.
- `ack`  out  1  one-cycle pulse when a request is accepted.
- `busy`  out  1  high while a press sequence is in progress.
- `done`  out  1  one-cycle pulse when the key is fully released.
- `col`  in  4  scanner column drive; active-high, nominally one-hot.
- `row`  out  4  row return; active-high.

## Operation
- **Reset values:** `ack`=0, `busy`=0, `done`=0, `row`=0, contact=0, state IDLE, all counters 0.
- **Internal contact bit:** `row` = onehot(`key_code_q[3:2]`) when contact=1 and `col[key_code_q[1:0]]`=1; otherwise 0.
  - `row` is combinational from `col` and has zero latency.
  - Non-one-hot `col` still uses only the selected bit.
- **IDLE:** when `req`=1 at a clock edge, latch `key_code` into `key_code_q`, pulse `ack`, and go to BOUNCE_IN. `req` is ignored in all other states.
- **BOUNCE_IN:** the contact sequence is (1 for `BOUNCE_CLKS`, 0 for `BOUNCE_CLKS`) × `BOUNCE_TOGGLES`, then HOLD with contact=1. With `BOUNCE_TOGGLES`=0, go directly to HOLD.
- **HOLD:** contact=1. Count rising edges of `col[3]` (end of scan). After the `HOLD_SCANS`-th edge, go to BOUNCE_OUT. A stalled scanner (no `col[3]` edges) keeps the key held indefinitely, by design.
- **BOUNCE_OUT:** the contact sequence is (0 for `BOUNCE_CLKS`, 1 for `BOUNCE_CLKS`) × `BOUNCE_TOGGLES`, then DONE with contact=0.
- **DONE:** pulse `done` for one cycle, then return to IDLE. A new `req` is accepted at the earliest on the cycle after DONE.
- **`busy`:** 1 in every state except IDLE, including the DONE cycle.
- **Width rules:**
  - Phase counter width: `$clog2(BOUNCE_CLKS)`.
  - Scan counter width: `$clog2(HOLD_SCANS+1)`.
  - Bounce pair counter width: `$clog2(BOUNCE_TOGGLES+1)`.
  - No counter wraps; every counter clears on state entry.
- **Reset mid-operation:** `row` drops to 0 asynchronously, the FSM returns to IDLE, and no `done` is issued.

## Timing
- Request accepted at edge t:
  - `ack`=1 and `busy`=1 during cycle t+1.
  - contact=1 from t+1.
  - `row` reflects contact in the same cycle as the matching `col`.
- Press duration, bounce portion: exactly 2·`BOUNCE_TOGGLES`·`BOUNCE_CLKS` clocks at each of the press and release ends.
- `done` rises exactly 2·`BOUNCE_TOGGLES`·`BOUNCE_CLKS` clocks after the cycle in which the `HOLD_SCANS`-th `col[3]` rising edge is registered.
- The `col[3]` edge detect uses a one-flop delay. An edge is registered the cycle after `col[3]` goes 0→1.

## Structure
- **Shared package `keypad_pkg`:**
  - state enum (IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, DONE);
  - `key_code` field positions (ROW_MSB=3, ROW_LSB=2, COL_MSB=1, COL_LSB=0);
  - a `onehot4` function.
  - The scanner and this block share the package.
- **Sub-module `contact_bouncer`:** phase and pair counters that generate the bounce waveform.
  - Inputs: `start`, `polarity` (press or release).
  - Outputs: `contact_level`, `finished`.
  - It is instantiated once and reused for both bounce phases.

## Test plan
- **Clean press, key 4'h6:** `BOUNCE_TOGGLES`=0, `HOLD_SCANS`=2, ideal scanner rotating `col` 0001→0010→0100→1000 every 4 clks.
  - `row`=4'b0010 only while `col`=4'b0100.
  - `done` after 2 `col[3]` edges.
  - `row`=0 afterwards.
- **Bounce, key 4'hF:** `BOUNCE_TOGGLES`=3, `BOUNCE_CLKS`=10, `col` held 4'b1000.
  - `row` toggles 4'b1000/0 every 10 clks, 6 phases, then is steady.
  - The release mirrors this, starting at 0.
  - Total bounce 60+60 clks.
- **`req` while busy:** assert `req` with key 4'h3 in HOLD.
  - No `ack`; `key_code_q` unchanged.
  - The held `req` is accepted in IDLE the cycle after DONE.
- **Async reset in HOLD:** pull `reset_n` low mid-hold.
  - `row`=0 immediately, `busy`=0, no `done`.
  - After release, a new `req` is accepted normally.
- **Loopback with scanner and decoder:** press codes 1, 1, 2.
  - The downstream counter ends at 16'h0001.
  - Each press yields exactly one `key_valid` rising edge despite bounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Definitions shared by the keypad scanner and the keypad responder:
// FSM states, key_code field positions and the row/column one-hot helper.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        DONE
    } kp_state_t;

    localparam int ROW_MSB = 3;
    localparam int ROW_LSB = 2;
    localparam int COL_MSB = 1;
    localparam int COL_LSB = 0;

    // Contact level during the first half of each bounce pair.
    localparam logic POL_PRESS   = 1'b1;
    localparam logic POL_RELEASE = 1'b0;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/keypad_responder_if.sv
// Request handshake plus keypad matrix lines between a scanner-side master
// and the key-side responder.
interface keypad_responder_if;
    logic       req;
    logic [3:0] key_code;
    logic       ack;
    logic       busy;
    logic       done;
    logic [3:0] col;
    logic [3:0] row;

    modport master (output req, key_code, col, input ack, busy, done, row);
    modport slave  (input req, key_code, col, output ack, busy, done, row);
endinterface

// File: rtl/keypad_responder_bouncer.sv
// Bounce waveform generator: BOUNCE_TOGGLES pairs of BOUNCE_CLKS-long phases,
// first half at the latched polarity and second half inverted.
module contact_bouncer #(
    parameter int BOUNCE_TOGGLES = 3,
    parameter int BOUNCE_CLKS    = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic polarity,
    output logic contact_level,
    output logic finished
);
    localparam int PHASE_W = (BOUNCE_CLKS > 1) ? $clog2(BOUNCE_CLKS) : 1;
    localparam int PAIR_W  = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BOUNCE_CLKS - 1);
    localparam logic [PAIR_W-1:0]  LAST_PAIR  =
        PAIR_W'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);

    logic               running;
    logic               second_half;
    logic               pol_q;
    logic [PHASE_W-1:0] phase_cnt;
    logic [PAIR_W-1:0]  pair_cnt;
    logic               phase_end;

    assign phase_end     = (phase_cnt == LAST_PHASE);
    assign finished      = running && second_half && phase_end && (pair_cnt == LAST_PAIR);
    assign contact_level = running && (second_half ? ~pol_q : pol_q);

    // A start restarts the whole sequence, so the unit can serve press and release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running     <= 1'b0;
            second_half <= 1'b0;
            pol_q       <= 1'b0;
            phase_cnt   <= '0;
            pair_cnt    <= '0;
        end else if (start) begin
            running     <= 1'b1;
            second_half <= 1'b0;
            pol_q       <= polarity;
            phase_cnt   <= '0;
            pair_cnt    <= '0;
        end else if (running) begin
            if (finished) begin
                running <= 1'b0;
            end else if (phase_end) begin
                phase_cnt   <= '0;
                second_half <= ~second_half;
                if (second_half) begin
                    pair_cnt <= pair_cnt + PAIR_W'(1);
                end
            end else begin
                phase_cnt <= phase_cnt + PHASE_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_responder.sv
// Key side of the keypad matrix: plays a bounced press/hold/release of one key
// back to the scanner by returning rows for the driven columns.
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int HOLD_SCANS     = 8,
    parameter int BOUNCE_TOGGLES = 3,
    parameter int BOUNCE_CLKS    = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    keypad_responder_if.slave  kp
);
    localparam int SCAN_W = $clog2(HOLD_SCANS + 1);
    localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(HOLD_SCANS - 1);
    localparam bit HAS_BOUNCE = (BOUNCE_TOGGLES > 0);

    kp_state_t         state;
    kp_state_t         state_nxt;
    logic [3:0]        key_code_q;
    logic              ack_q;
    logic              col3_q;
    logic              scan_rise;
    logic [SCAN_W-1:0] scan_cnt;
    logic              contact;
    logic              bounce_start;
    logic              bounce_pol;
    logic              bounce_level;
    logic              bounce_finished;

    contact_bouncer #(
        .BOUNCE_TOGGLES (BOUNCE_TOGGLES),
        .BOUNCE_CLKS    (BOUNCE_CLKS)
    ) u_bouncer (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (bounce_start),
        .polarity      (bounce_pol),
        .contact_level (bounce_level),
        .finished      (bounce_finished)
    );

    // A rising col[3] marks the end of one full scan of the matrix.
    assign scan_rise = kp.col[3] && !col3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            key_code_q <= '0;
            ack_q      <= 1'b0;
            col3_q     <= 1'b0;
            scan_cnt   <= '0;
        end else begin
            state  <= state_nxt;
            ack_q  <= (state == IDLE) && kp.req;
            col3_q <= kp.col[3];
            if ((state == IDLE) && kp.req) begin
                key_code_q <= kp.key_code;
            end
            if (state != HOLD) begin
                scan_cnt <= '0;
            end else if (scan_rise) begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bounce_start = 1'b0;
        bounce_pol   = POL_PRESS;
        contact      = 1'b0;
        case (state)
            IDLE: begin
                if (kp.req) begin
                    bounce_start = HAS_BOUNCE;
                    state_nxt    = HAS_BOUNCE ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN: begin
                contact = bounce_level;
                if (bounce_finished) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                contact = 1'b1;
                if (scan_rise && (scan_cnt == LAST_SCAN)) begin
                    bounce_start = HAS_BOUNCE;
                    bounce_pol   = POL_RELEASE;
                    state_nxt    = HAS_BOUNCE ? BOUNCE_OUT : DONE;
                end
            end
            BOUNCE_OUT: begin
                contact = bounce_level;
                if (bounce_finished) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Row return is combinational so the scanner sees the key in the same cycle.
    assign kp.row  = (contact && kp.col[key_code_q[COL_MSB:COL_LSB]])
                     ? onehot4(key_code_q[ROW_MSB:ROW_LSB]) : 4'b0000;
    assign kp.ack  = ack_q;
    assign kp.busy = (state != IDLE);
    assign kp.done = (state == DONE);

endmodule

// File: tb/tb_keypad_responder.sv
// Self-checking bench: a clean-edge responder and a bouncing responder driven
// by an ideal rotating scanner, with expected outputs queued per cycle.
module tb_keypad_responder;
    localparam int C_HOLD = 2;

    typedef struct packed {
        logic       ack;
        logic       busy;
        logic       done;
        logic [3:0] row;
    } obs_t;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;
    obs_t exp_q[$];

    int         m_state;
    logic [3:0] m_key;
    int         m_edges;
    logic       m_prev3;
    logic       m_ack;

    keypad_responder_if ifc_c ();
    keypad_responder_if ifc_b ();

    keypad_responder #(
        .HOLD_SCANS     (C_HOLD),
        .BOUNCE_TOGGLES (0),
        .BOUNCE_CLKS    (1)
    ) dut_c (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (ifc_c)
    );

    keypad_responder #(
        .HOLD_SCANS     (2),
        .BOUNCE_TOGGLES (3),
        .BOUNCE_CLKS    (10)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .kp      (ifc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behaviour of a clean-edge key: idle -> held -> done -> idle.
    task automatic model_reset();
        m_state = 0;
        m_key   = 4'h0;
        m_edges = 0;
        m_prev3 = 1'b0;
        m_ack   = 1'b0;
    endtask

    task automatic model_step(input logic req, input logic [3:0] key,
                              input logic [3:0] col, output obs_t e);
        logic [3:0] sel;
        sel    = 4'b0001 << m_key[3:2];
        e.ack  = m_ack;
        e.busy = (m_state != 0);
        e.done = (m_state == 2);
        e.row  = ((m_state == 1) && col[m_key[1:0]]) ? sel : 4'b0000;
        m_ack  = (m_state == 0) && req;
        case (m_state)
            0: if (req) begin
                m_state = 1;
                m_key   = key;
                m_edges = 0;
            end
            1: if (col[3] && !m_prev3) begin
                m_edges++;
                if (m_edges == C_HOLD) m_state = 2;
            end
            default: m_state = 0;
        endcase
        m_prev3 = col[3];
    endtask

    task automatic test_reset();
        obs_t obs;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {ifc_c.ack, ifc_c.busy, ifc_c.done, ifc_c.row};
        tests_run++;
        if (obs !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clean: got %b, expected 0000000", obs);
        end
        obs = {ifc_b.ack, ifc_b.busy, ifc_b.done, ifc_b.row};
        tests_run++;
        if (obs !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bounce: got %b, expected 0000000", obs);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_clean_press();
        obs_t e, obs;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            ifc_c.req      = (k == 0);
            ifc_c.key_code = 4'h6;
            ifc_c.col      = 4'(4'b0001 << ((k / 4) % 4));
            model_step(ifc_c.req, ifc_c.key_code, ifc_c.col, e);
            exp_q.push_back(e);
            #1;
            obs = {ifc_c.ack, ifc_c.busy, ifc_c.done, ifc_c.row};
            e   = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("[TB] FAIL clean_press step %0d: got ack=%b busy=%b done=%b row=%b, expected ack=%b busy=%b done=%b row=%b",
                         k, obs.ack, obs.busy, obs.done, obs.row, e.ack, e.busy, e.done, e.row);
            end
        end
    endtask

    task automatic test_bounce();
        obs_t e, obs;
        int   edges     = 0;
        int   rel_start = -1;
        logic prev3     = ifc_b.col[3];
        logic cont;
        for (int k = 0; k <= 150; k++) begin
            @(negedge clk);
            ifc_b.req      = (k == 0);
            ifc_b.key_code = 4'hF;
            ifc_b.col      = (k == 70 || k == 80) ? 4'b0000 : 4'b1000;
            if (k == 0)                      cont = 1'b0;
            else if (k <= 60)                cont = (((k - 1) / 10) % 2) == 0;
            else if (rel_start < 0)          cont = 1'b1;
            else if (k < rel_start + 60)     cont = (((k - rel_start) / 10) % 2) == 1;
            else                             cont = 1'b0;
            e.ack  = (k == 1);
            e.busy = (k >= 1) && (rel_start < 0 || k <= rel_start + 60);
            e.done = (rel_start >= 0) && (k == rel_start + 60);
            e.row  = (cont && ifc_b.col[3]) ? 4'b1000 : 4'b0000;
            if (k > 60 && rel_start < 0 && ifc_b.col[3] && !prev3) begin
                edges++;
                if (edges == 2) rel_start = k + 1;
            end
            prev3 = ifc_b.col[3];
            exp_q.push_back(e);
            #1;
            obs = {ifc_b.ack, ifc_b.busy, ifc_b.done, ifc_b.row};
            e   = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("[TB] FAIL bounce step %0d: got ack=%b busy=%b done=%b row=%b, expected ack=%b busy=%b done=%b row=%b",
                         k, obs.ack, obs.busy, obs.done, obs.row, e.ack, e.busy, e.done, e.row);
            end
        end
    endtask

    task automatic test_req_while_busy();
        obs_t e, obs;
        int   acks = 0;
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            ifc_c.req      = (k == 0) || (k >= 5 && k <= 30);
            ifc_c.key_code = (k < 5) ? 4'h6 : 4'h3;
            ifc_c.col      = 4'(4'b0001 << ((k / 4) % 4));
            model_step(ifc_c.req, ifc_c.key_code, ifc_c.col, e);
            exp_q.push_back(e);
            #1;
            obs = {ifc_c.ack, ifc_c.busy, ifc_c.done, ifc_c.row};
            e   = exp_q.pop_front();
            if (obs.ack === 1'b1) acks++;
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("[TB] FAIL req_while_busy step %0d: got ack=%b busy=%b done=%b row=%b, expected ack=%b busy=%b done=%b row=%b",
                         k, obs.ack, obs.busy, obs.done, obs.row, e.ack, e.busy, e.done, e.row);
            end
        end
        tests_run++;
        if (acks !== 2) begin
            tests_failed++;
            $display("[TB] FAIL req_while_busy_acks: got %0d acks, expected 2", acks);
        end
    endtask

    task automatic test_async_reset();
        obs_t e, obs;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k == 13) begin
                reset_n = 1'b1;
                model_reset();
            end
            ifc_c.req      = (k == 0) || (k == 20);
            ifc_c.key_code = (k < 20) ? 4'h6 : 4'h9;
            ifc_c.col      = 4'(4'b0001 << ((k / 4) % 4));
            if (k == 11 || k == 12) continue;
            model_step(ifc_c.req, ifc_c.key_code, ifc_c.col, e);
            exp_q.push_back(e);
            #1;
            obs = {ifc_c.ack, ifc_c.busy, ifc_c.done, ifc_c.row};
            e   = exp_q.pop_front();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("[TB] FAIL async_reset step %0d: got ack=%b busy=%b done=%b row=%b, expected ack=%b busy=%b done=%b row=%b",
                         k, obs.ack, obs.busy, obs.done, obs.row, e.ack, e.busy, e.done, e.row);
            end
            if (k == 10) begin
                #2;
                reset_n = 1'b0;
                #1;
                obs = {ifc_c.ack, ifc_c.busy, ifc_c.done, ifc_c.row};
                tests_run++;
                if (obs !== 7'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL async_reset_immediate: got %b, expected 0000000", obs);
                end
            end
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset_n        = 1'b0;
        ifc_c.req      = 1'b0;
        ifc_c.key_code = 4'h0;
        ifc_c.col      = 4'h0;
        ifc_b.req      = 1'b0;
        ifc_b.key_code = 4'h0;
        ifc_b.col      = 4'h0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_req_while_busy();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
